dendrite_compartment: RTL and testbench



---
 rtl/dendrite_compartment_pkg.sv | 39 +++
 rtl/dendrite_compartment_if.sv | 32 +++
 rtl/dendrite_compartment_cfg_chain.sv | 38 +++
 rtl/dendrite_compartment.sv | 149 ++++++++++++++
 tb/tb_dendrite_compartment.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dendrite_compartment_pkg.sv
// fp: shared fixed-point types, compartment state encoding and the final
// narrowing helper used by dendrite_compartment.
// Build option: DENDRITE_SAT_EN selects saturating narrowing in sat_narrow;
// when it is undefined, narrowing truncates (two's-complement wrap).
package fp;

  localparam int WORD_LENGTH = 16;

  typedef logic signed [WORD_LENGTH-1:0] fpType;

  // Accumulator type sized for the largest legal synapse count (64) at the
  // default word length.
  typedef logic signed [WORD_LENGTH+$clog2(64)+3-1:0] fpWideType;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    LEAK   = 2'd2,
    UPDATE = 2'd3
  } comp_state_e;

  // Narrows x to a w-bit signed value, returned sign-extended to 64 bits.
  // Callers take the low w bits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                    input int w);
`ifdef DENDRITE_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
`else
    return (x <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/dendrite_compartment_if.sv
// dendrite_compartment_if: update handshake and synapse-facing signals.
//   step        : one-cycle update request (master -> slave)
//   syn_current : NUM_SYN packed signed synaptic currents (master -> slave)
//   busy        : update in progress, including the done cycle (slave -> master)
//   done        : one-cycle pulse with a new vmem (slave -> master)
//   overrun     : sticky step-while-busy flag (slave -> master)
//   vmem        : membrane voltage broadcast (slave -> master)
interface dendrite_compartment_if
  import fp::*;
#(
  parameter int WIDTH   = WORD_LENGTH,
  parameter int NUM_SYN = 4
);

  logic                            step;
  logic [NUM_SYN-1:0][WIDTH-1:0]   syn_current;
  logic                            busy;
  logic                            done;
  logic                            overrun;
  logic [WIDTH-1:0]                vmem;

  modport master (
    output step, syn_current,
    input  busy, done, overrun, vmem
  );

  modport slave (
    input  step, syn_current,
    output busy, done, overrun, vmem
  );

endinterface

// File: rtl/dendrite_compartment_cfg_chain.sv
// dendrite_cfg_chain: three-word serial configuration chain with a registered
// serial output. Order: data_in -> e_l -> tau_mem -> g_ax -> data_out.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   shift_en   : advance the chain by one word
//   data_in    : serial input word
//   data_out   : serial output word (previous g_ax)
//   e_l, tau_mem, g_ax : parallel configuration words
module dendrite_cfg_chain
  import fp::*;
#(
  parameter int WIDTH = WORD_LENGTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] e_l,
  output logic [WIDTH-1:0] tau_mem,
  output logic [WIDTH-1:0] g_ax
);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_l      <= '0;
      tau_mem  <= '0;
      g_ax     <= '0;
      data_out <= '0;
    end else if (shift_en) begin
      e_l      <= data_in;
      tau_mem  <= e_l;
      g_ax     <= tau_mem;
      data_out <= g_ax;
    end
  end

endmodule

// File: rtl/dendrite_compartment.sv
// dendrite_compartment: time-multiplexed dendritic compartment. Integrates
// NUM_SYN synaptic currents, the upstream axial current, a leak toward E_l and
// the axial coupling to the downstream compartment into a signed membrane
// voltage, one update per step pulse.
// Build option: DENDRITE_SAT_EN makes the final vmem/lower_current narrowing
// saturate; otherwise it wraps.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   bus (slave)    : step, syn_current, busy, done, overrun, vmem
//   upper_vmem     : copy of vmem for the upstream compartment
//   upper_current  : axial current from the upstream compartment
//   lower_vmem     : downstream compartment voltage
//   lower_current  : registered coupling current to the downstream compartment
//   cfg_shift, cfg_data_in, cfg_data_out : serial configuration chain
//
// state  | meaning
// IDLE   | waiting for step; configuration chain may shift
// ACCUM  | adds one synaptic current per cycle
// LEAK   | adds upstream current, leak and minus coupling
// UPDATE | commits vmem and lower_current, pulses done
module dendrite_compartment
  import fp::*;
#(
  parameter int WIDTH      = WORD_LENGTH,
  parameter int NUM_SYN    = 4,
  parameter int LEAK_SHIFT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  dendrite_compartment_if.slave bus,
  output logic [WIDTH-1:0]      upper_vmem,
  input  logic [WIDTH-1:0]      upper_current,
  input  logic [WIDTH-1:0]      lower_vmem,
  output logic [WIDTH-1:0]      lower_current,
  input  logic                  cfg_shift,
  input  logic [WIDTH-1:0]      cfg_data_in,
  output logic [WIDTH-1:0]      cfg_data_out
);

  localparam int IW = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
  localparam int AW = WIDTH + $clog2(NUM_SYN) + 3;
  localparam int PW = 2 * WIDTH + 2;
  localparam int SW = ((PW > AW) ? PW : AW) + 1;

  comp_state_e          state;
  logic [IW-1:0]        idx;
  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] cpl_q;
  logic [WIDTH-1:0]     vmem_q;
  logic [WIDTH-1:0]     lower_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 overrun_q;

  logic [WIDTH-1:0]     e_l, tau_mem, g_ax;
  logic [WIDTH-1:0]     e_l_s, tau_s, g_ax_s;

  // busy_q trails the state by one cycle, so the done cycle (state already
  // IDLE) still counts as busy: no new step or shift is accepted in it.
  logic blocked;
  assign blocked = (state != IDLE) || busy_q;

  dendrite_cfg_chain #(.WIDTH(WIDTH)) u_cfg (
    .clk      (clk),
    .reset    (reset),
    .shift_en (cfg_shift && !blocked),
    .data_in  (cfg_data_in),
    .data_out (cfg_data_out),
    .e_l      (e_l),
    .tau_mem  (tau_mem),
    .g_ax     (g_ax)
  );

  logic signed [WIDTH:0]  dv_leak, dv_cpl, tau_x, gax_x;
  logic signed [PW-1:0]   prod_leak, prod_cpl, leak, cpl;
  logic signed [SW-1:0]   leak_sum, vsum;

  always_comb begin
    dv_leak   = {e_l_s[WIDTH-1], e_l_s} - {vmem_q[WIDTH-1], vmem_q};
    dv_cpl    = {vmem_q[WIDTH-1], vmem_q} - {lower_vmem[WIDTH-1], lower_vmem};
    tau_x     = {1'b0, tau_s};
    gax_x     = {1'b0, g_ax_s};
    prod_leak = PW'(dv_leak) * PW'(tau_x);
    prod_cpl  = PW'(dv_cpl) * PW'(gax_x);
    leak      = prod_leak >>> LEAK_SHIFT;
    cpl       = prod_cpl >>> LEAK_SHIFT;
    leak_sum  = SW'(acc) + SW'($signed(upper_current)) + SW'(leak) - SW'(cpl);
    vsum      = SW'($signed(vmem_q)) + SW'(acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      cpl_q     <= '0;
      vmem_q    <= '0;
      lower_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      e_l_s     <= '0;
      tau_s     <= '0;
      g_ax_s    <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state != IDLE);
      if (bus.step && blocked) overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.step && !busy_q) begin
            acc    <= '0;
            idx    <= '0;
            // Snapshot so a same-cycle shift cannot affect this update.
            e_l_s  <= e_l;
            tau_s  <= tau_mem;
            g_ax_s <= g_ax;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + AW'($signed(bus.syn_current[idx]));
          idx <= idx + IW'(1);
          if (idx == IW'(NUM_SYN - 1)) state <= LEAK;
        end
        LEAK: begin
          acc   <= leak_sum[AW-1:0];
          cpl_q <= cpl;
          state <= UPDATE;
        end
        UPDATE: begin
          vmem_q  <= WIDTH'(sat_narrow(64'(vsum), WIDTH));
          lower_q <= WIDTH'(sat_narrow(64'(cpl_q), WIDTH));
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;
  assign bus.vmem      = vmem_q;
  assign upper_vmem    = vmem_q;
  assign lower_current = lower_q;

endmodule

// File: tb/tb_dendrite_compartment.sv
// Testbench for dendrite_compartment (WIDTH=16, NUM_SYN=4, LEAK_SHIFT=15).
module tb_dendrite_compartment;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int LS = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] upper_vmem, upper_current, lower_vmem, lower_current;
  logic         cfg_shift;
  logic [W-1:0] cfg_data_in, cfg_data_out;

  always #5 clk = ~clk;

  dendrite_compartment_if #(.WIDTH(W), .NUM_SYN(N)) bus ();

  dendrite_compartment #(.WIDTH(W), .NUM_SYN(N), .LEAK_SHIFT(LS)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .upper_vmem    (upper_vmem),
    .upper_current (upper_current),
    .lower_vmem    (lower_vmem),
    .lower_current (lower_current),
    .cfg_shift     (cfg_shift),
    .cfg_data_in   (cfg_data_in),
    .cfg_data_out  (cfg_data_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int v;
    int lc;
    int t;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // Reference model state: configuration words and membrane voltage.
  logic [W-1:0] q_el, q_tau, q_gax, q_out;
  int m_v;

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int narrow(input longint x);
`ifdef DENDRITE_SAT_EN
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
`else
    logic [W-1:0] t;
    t = x[W-1:0];
    return sx(t);
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_el = '0; q_tau = '0; q_gax = '0; q_out = '0; m_v = 0;
  endtask

  task automatic model_shift(input logic [W-1:0] w);
    q_out = q_gax; q_gax = q_tau; q_tau = q_el; q_el = w;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.done) begin
        if (sbq.size() == 0) begin
          check("spurious_done_queue_depth", sbq.size(), 1);
        end else begin
          mon_e = sbq.pop_front();
          check("vmem", sx(bus.vmem), mon_e.v);
          check("lower_current", sx(lower_current), mon_e.lc);
          check("upper_vmem", sx(upper_vmem), mon_e.v);
          check("done_cycle", cyc, mon_e.t);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic shift_word(input logic [W-1:0] w);
    @(negedge clk);
    cfg_shift   = 1'b1;
    cfg_data_in = w;
    @(negedge clk);
    cfg_shift = 1'b0;
    model_shift(w);
  endtask

  task automatic set_cfg(input int el, input int tau, input int gax);
    shift_word(W'(gax));
    shift_word(W'(tau));
    shift_word(W'(el));
  endtask

  // One update. shift_too shifts shw in the step cycle; extra issues a second
  // step two cycles later and a shift attempt while busy.
  task automatic do_update(input int syn[N], input int up, input int low,
                           input bit shift_too, input logic [W-1:0] shw,
                           input bit extra);
    longint sum, leak, cpl, acc;
    exp_t e;
    int nb, k;
    @(negedge clk);
    for (int i = 0; i < N; i++) bus.syn_current[i] = W'(syn[i]);
    upper_current = W'(up);
    lower_vmem    = W'(low);
    bus.step      = 1'b1;
    cfg_shift     = shift_too;
    cfg_data_in   = shw;
    sum = 0;
    for (int i = 0; i < N; i++) sum += sx(W'(syn[i]));
    leak = (longint'(sx(q_el) - m_v) * longint'(q_tau)) >>> LS;
    cpl  = (longint'(m_v - sx(W'(low))) * longint'(q_gax)) >>> LS;
    acc  = sum + sx(W'(up)) + leak - cpl;
    e.v  = narrow(longint'(m_v) + acc);
    e.lc = narrow(cpl);
    e.t  = cyc + 1 + N + 2;
    sbq.push_back(e);
    m_v = e.v;
    if (shift_too) model_shift(shw);
    @(negedge clk);
    bus.step  = 1'b0;
    cfg_shift = 1'b0;
    nb = bus.busy;
    k  = 0;
    while (!bus.done && k < 30) begin
      @(negedge clk);
      k++;
      bus.step    = (extra && k == 1);
      cfg_shift   = (extra && k == 2);
      cfg_data_in = 16'hBEEF;
      nb += bus.busy;
    end
    bus.step  = 1'b0;
    cfg_shift = 1'b0;
    check("done_seen", bus.done, 1);
    @(negedge clk);
    check("busy_cycles", nb, N + 2);
    check("busy_after_done", bus.busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s[N];
    int delta;
    reset            = 1'b1;
    bus.step         = 1'b0;
    bus.syn_current  = '0;
    upper_current    = '0;
    lower_vmem       = '0;
    cfg_shift        = 1'b0;
    cfg_data_in      = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_vmem", sx(bus.vmem), 0);
    check("rst_lower_current", sx(lower_current), 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_cfg_data_out", cfg_data_out, 0);

    // Plain accumulation.
    do_update('{100, 200, 300, 400}, 0, 0, 0, '0, 0);
    check("t1_vmem", sx(bus.vmem), 1000);

    // Leak toward E_l = 0 halves vmem.
    set_cfg(0, 16384, 0);
    do_update('{0, 0, 0, 0}, 0, 0, 0, '0, 0);
    check("t2_vmem_a", sx(bus.vmem), 500);
    do_update('{0, 0, 0, 0}, 0, 0, 0, '0, 0);
    check("t2_vmem_b", sx(bus.vmem), 250);

    // Overflow of the final narrowing.
    set_cfg(0, 0, 0);
    delta = 32000 - m_v;
    s = '{delta / 4, delta / 4, delta / 4, delta - 3 * (delta / 4)};
    do_update(s, 0, 0, 0, '0, 0);
    check("t3_pre_vmem", sx(bus.vmem), 32000);
    do_update('{1000, 1000, 1000, 1000}, 0, 0, 0, '0, 0);
`ifdef DENDRITE_SAT_EN
    check("t3_sat_vmem", sx(bus.vmem), 32767);
`else
    check("t3_wrap_vmem", sx(bus.vmem), -29536);
`endif

    // Axial coupling.
    do_reset();
    set_cfg(0, 0, 32768);
    do_update('{0, 0, 0, 0}, 0, -400, 0, '0, 0);
    check("t4_lower_current", sx(lower_current), 400);
    do_reset();
    set_cfg(0, 0, 32768);
    do_update('{0, 0, 0, 0}, 50, -400, 0, '0, 0);
    check("t4_vmem_upper", sx(bus.vmem), -350);

    // Overrun and shift while busy.
    do_update('{10, 20, 30, 40}, 7, 123, 0, '0, 1);
    check("t5_overrun", bus.overrun, 1);
    check("t5_cfg_out_kept", cfg_data_out, q_out);
    do_update('{-5, 6, -7, 8}, 0, 300, 0, '0, 0);

    // Reset during the third accumulate cycle aborts the update.
    @(negedge clk);
    bus.syn_current = '0;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    check("t6_vmem", sx(bus.vmem), 0);
    check("t6_overrun_cleared", bus.overrun, 0);
    check("t6_busy", bus.busy, 0);

    // Chain order: A ends in g_ax, C in E_l; a 4th shift emits A.
    shift_word(16'd20000);
    shift_word(16'd3000);
    shift_word(16'hFB2E);
    do_update('{11, -22, 33, -44}, 5, -900, 0, '0, 0);
    shift_word(16'h0777);
    check("t6_cfg_data_out", cfg_data_out, 20000);

    // Randomized updates, some with a same-cycle configuration shift.
    for (int it = 0; it < 30; it++) begin
      int rs[N];
      for (int i = 0; i < N; i++) rs[i] = sx(W'($urandom));
      if ($urandom_range(0, 4) == 0) shift_word(W'($urandom));
      do_update(rs, sx(W'($urandom)), sx(W'($urandom)),
                ($urandom_range(0, 2) == 0), W'($urandom), 0);
    end
    check("final_cfg_data_out", cfg_data_out, q_out);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
